// File: rtl/nes_multipad_reader.sv
// Multi-pad NES/SNES serial controller reader: drives shared latch and shift clock,
// deserialises every pad in parallel and publishes button state with edge flags.
module nes_multipad_reader #(
    parameter int NUM_PADS      = 2,
    parameter int BITS          = 8,
    parameter int HALF_PERIOD   = 3,
    parameter int LATCH_CYCLES  = 11,
    parameter int POLL_INTERVAL = 15000
) (
    input  logic                     clk_900KHz,
    input  logic                     reset,
    input  logic [NUM_PADS-1:0]      data_in,
    input  logic                     poll_en,
    output logic                     latch_out,
    output logic                     pad_clk_out,
    output logic [NUM_PADS*BITS-1:0] buttons,
    output logic [NUM_PADS*BITS-1:0] pressed,
    output logic [NUM_PADS*BITS-1:0] released,
    output logic                     frame_valid,
    output logic                     busy
);

    localparam int W         = NUM_PADS * BITS;
    localparam int PHASE_MAX = (LATCH_CYCLES > HALF_PERIOD) ? LATCH_CYCLES : HALF_PERIOD;
    localparam int CW        = $clog2(PHASE_MAX + 1);
    localparam int IW        = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
    localparam int BW        = $clog2(BITS + 1);

    localparam logic [CW-1:0] LATCH_LAST = CW'(LATCH_CYCLES - 1);
    localparam logic [CW-1:0] HALF_LAST  = CW'(HALF_PERIOD - 1);
    localparam logic [IW-1:0] RELOAD     = IW'(POLL_INTERVAL - 1);
    localparam logic [BW-1:0] BITS_W     = BW'(BITS);

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        GAP,
        CLK_HI,
        CLK_LO,
        UPDATE
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   phase_q, phase_d;
    logic [BW-1:0]   bit_q, bit_d;
    logic [IW-1:0]   interval_q, interval_d;
    logic [NUM_PADS-1:0] sync1_q, sync2_q;
    logic [W-1:0]    shift_q, shift_d;
    logic [W-1:0]    buttons_q, pressed_q, released_q;
    logic            latch_q, pclk_q, fv_q, busy_q;
    logic            sample;
    logic [BITS-1:0] lane;

    always_comb begin
        state_d = state_q;
        phase_d = phase_q + 1'b1;
        bit_d   = bit_q;
        sample  = 1'b0;
        case (state_q)
            IDLE: begin
                phase_d = '0;
                bit_d   = '0;
                if (poll_en && interval_q == '0) state_d = LATCH;
            end
            LATCH: begin
                if (phase_q == LATCH_LAST) begin
                    state_d = GAP;
                    phase_d = '0;
                end
            end
            GAP: begin
                if (phase_q == HALF_LAST) begin
                    sample  = 1'b1;
                    bit_d   = BW'(1);
                    phase_d = '0;
                    state_d = (BITS > 1) ? CLK_HI : UPDATE;
                end
            end
            CLK_HI: begin
                if (phase_q == HALF_LAST) begin
                    state_d = CLK_LO;
                    phase_d = '0;
                end
            end
            CLK_LO: begin
                if (phase_q == HALF_LAST) begin
                    sample  = 1'b1;
                    bit_d   = bit_q + 1'b1;
                    phase_d = '0;
                    state_d = (bit_q + 1'b1 < BITS_W) ? CLK_HI : UPDATE;
                end
            end
            UPDATE: begin
                state_d = IDLE;
                phase_d = '0;
            end
            default: begin
                state_d = IDLE;
                phase_d = '0;
            end
        endcase
    end

    // Frame-to-frame spacing counts from LATCH entry, so it keeps running during the frame.
    always_comb begin
        interval_d = interval_q;
        if (state_q == IDLE && state_d == LATCH) interval_d = RELOAD;
        else if (interval_q != '0) interval_d = interval_q - 1'b1;
    end

    // Each pad lane shifts right so the first bit received ends up at bit 0.
    always_comb begin
        shift_d = shift_q;
        lane    = '1;
        if (sample) begin
            for (int p = 0; p < NUM_PADS; p++) begin
                lane            = shift_q[p*BITS +: BITS] >> 1;
                lane[BITS-1]    = sync2_q[p];
                shift_d[p*BITS +: BITS] = lane;
            end
        end
    end

    always_ff @(posedge clk_900KHz or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            phase_q    <= '0;
            bit_q      <= '0;
            interval_q <= '0;
            sync1_q    <= '1;
            sync2_q    <= '1;
            shift_q    <= '1;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            bit_q      <= bit_d;
            interval_q <= interval_d;
            sync1_q    <= data_in;
            sync2_q    <= sync1_q;
            shift_q    <= shift_d;
        end
    end

    // Pin strobes are registered from the next state so they stay glitch-free yet line up with the FSM.
    always_ff @(posedge clk_900KHz or negedge reset) begin
        if (!reset) begin
            latch_q    <= 1'b0;
            pclk_q     <= 1'b0;
            busy_q     <= 1'b0;
            fv_q       <= 1'b0;
            buttons_q  <= '0;
            pressed_q  <= '0;
            released_q <= '0;
        end else begin
            latch_q <= (state_d == LATCH);
            pclk_q  <= (state_d == CLK_HI);
            busy_q  <= (state_d != IDLE);
            fv_q    <= (state_q == UPDATE);
            if (state_q == UPDATE) begin
                buttons_q  <= ~shift_q;
                pressed_q  <= ~shift_q & ~buttons_q;
                released_q <= shift_q & buttons_q;
            end
        end
    end

    assign latch_out   = latch_q;
    assign pad_clk_out = pclk_q;
    assign busy        = busy_q;
    assign frame_valid = fv_q;
    assign buttons     = buttons_q;
    assign pressed     = pressed_q;
    assign released    = released_q;

endmodule

// File: tb/tb_nes_multipad_reader.sv
// Directed bench for nes_multipad_reader: behavioural pad models on a default
// 2-pad/8-bit instance and a 4-pad/16-bit instance, checked against hand-computed values.
module tb_nes_multipad_reader;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        resetN;
    logic [1:0]  dataA;
    logic        pollEnA;
    logic        latchA, pclkA, fvA, busyA;
    logic [15:0] buttonsA, pressedA, releasedA;

    logic [3:0]  dataB;
    logic        pollEnB;
    logic        latchB, pclkB, fvB, busyB;
    logic [63:0] buttonsB, pressedB, releasedB;

    nes_multipad_reader dutA (
        .clk_900KHz (clock),
        .reset      (resetN),
        .data_in    (dataA),
        .poll_en    (pollEnA),
        .latch_out  (latchA),
        .pad_clk_out(pclkA),
        .buttons    (buttonsA),
        .pressed    (pressedA),
        .released   (releasedA),
        .frame_valid(fvA),
        .busy       (busyA)
    );

    nes_multipad_reader #(
        .NUM_PADS(4), .BITS(16), .HALF_PERIOD(4), .LATCH_CYCLES(11), .POLL_INTERVAL(100)
    ) dutB (
        .clk_900KHz (clock),
        .reset      (resetN),
        .data_in    (dataB),
        .poll_en    (pollEnB),
        .latch_out  (latchB),
        .pad_clk_out(pclkB),
        .buttons    (buttonsB),
        .pressed    (pressedB),
        .released   (releasedB),
        .frame_valid(fvB),
        .busy       (busyB)
    );

    // Pad models: load the active-low pattern on latch, shift towards bit 0 on each pad_clk rise.
    logic [7:0]  patA[2];
    logic [7:0]  padRegA[2];
    logic [15:0] patB[4];
    logic [15:0] padRegB[4];

    always @(posedge latchA) for (int p = 0; p < 2; p++) padRegA[p] = patA[p];
    always @(posedge pclkA)  for (int p = 0; p < 2; p++) padRegA[p] = {1'b1, padRegA[p][7:1]};
    always @(posedge latchB) for (int p = 0; p < 4; p++) padRegB[p] = patB[p];
    always @(posedge pclkB)  for (int p = 0; p < 4; p++) padRegB[p] = {1'b1, padRegB[p][15:1]};

    assign dataA = {padRegA[1][0], padRegA[0][0]};
    assign dataB = {padRegB[3][0], padRegB[2][0], padRegB[1][0], padRegB[0][0]};

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0]  pad0;
        logic [7:0]  pad1;
        logic [15:0] expButtons;
        logic [15:0] expPressed;
        logic [15:0] expReleased;
    } frameVec_t;

    frameVec_t vecs[3];

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] pad0, input logic [7:0] pad1);
        patA[0] = pad0;
        patA[1] = pad1;
    endtask

    // Waits for a latch rise, then follows the frame sample-by-sample at negedges until frame_valid.
    task automatic walkFrame(input bit useB, output int riseCyc, output int latchLen, output int pulses,
                             output int badHigh, output int badLow, output int fvIdx,
                             output logic [63:0] btn, output logic [63:0] prs, output logic [63:0] rel);
        int  half;
        int  hiRun, loRun;
        bit  prevP, found;
        logic l, p, f;
        half = useB ? 4 : 3;
        riseCyc = -1; latchLen = 0; pulses = 0; badHigh = 0; badLow = 0; fvIdx = -1;
        btn = '0; prs = '0; rel = '0;
        found = 1'b0;
        for (int k = 0; k < 20000; k++) begin
            @(negedge clock);
            l = useB ? latchB : latchA;
            if (l) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) return;
        riseCyc = cyc;
        hiRun = 0; loRun = 0; prevP = 1'b0;
        for (int idx = 0; idx < 400; idx++) begin
            if (idx > 0) @(negedge clock);
            l = useB ? latchB : latchA;
            p = useB ? pclkB : pclkA;
            f = useB ? fvB : fvA;
            if (l) latchLen++;
            if (p) begin
                if (!prevP) begin
                    pulses++;
                    if (pulses > 1 && loRun != half) badLow++;
                    hiRun = 0;
                end
                hiRun++;
                loRun = 0;
            end else begin
                if (prevP && hiRun != half) badHigh++;
                loRun++;
            end
            prevP = p;
            if (f) begin
                fvIdx = idx;
                btn = useB ? buttonsB : {48'b0, buttonsA};
                prs = useB ? pressedB : {48'b0, pressedA};
                rel = useB ? releasedB : {48'b0, releasedA};
                break;
            end
        end
    endtask

    int riseCyc, prevRise, latchLen, pulses, badHigh, badLow, fvIdx;
    logic [63:0] btn, prs, rel;

    initial begin
        int seen;
        int rises;
        bit prevP, found;

        resetN  = 1'b0;
        pollEnA = 1'b0;
        pollEnB = 1'b0;
        for (int p = 0; p < 2; p++) begin patA[p] = 8'hFF;  padRegA[p] = 8'hFF;  end
        for (int p = 0; p < 4; p++) begin patB[p] = 16'hFFFF; padRegB[p] = 16'hFFFF; end

        vecs[0] = '{8'hFE, 8'hFF, 16'h0001, 16'h0001, 16'h0000};
        vecs[1] = '{8'hFF, 8'h7F, 16'h8000, 16'h8000, 16'h0001};
        vecs[2] = '{8'hFF, 8'h7F, 16'h8000, 16'h0000, 16'h0000};

        repeat (3) @(negedge clock);
        checkOutput("rst_latch",    latchA,    0);
        checkOutput("rst_padclk",   pclkA,     0);
        checkOutput("rst_buttons",  buttonsA,  0);
        checkOutput("rst_pressed",  pressedA,  0);
        checkOutput("rst_released", releasedA, 0);
        checkOutput("rst_fv",       fvA,       0);
        checkOutput("rst_busy",     busyA,     0);
        checkOutput("rst_busyB",    busyB,     0);
        resetN = 1'b1;

        // With polling off nothing may move.
        seen = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clock);
            if (latchA || pclkA || busyA || fvA || buttonsA != 0 || latchB || busyB) seen++;
        end
        checkOutput("idle_quiet", seen, 0);

        prevRise = 0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(vecs[i].pad0, vecs[i].pad1);
            if (i == 0) pollEnA = 1'b1;
            walkFrame(1'b0, riseCyc, latchLen, pulses, badHigh, badLow, fvIdx, btn, prs, rel);
            checkOutput($sformatf("f%0d_fv_latency", i), fvIdx, 57);
            checkOutput($sformatf("f%0d_latch_len", i), latchLen, 11);
            checkOutput($sformatf("f%0d_pulses", i), pulses, 7);
            checkOutput($sformatf("f%0d_bad_high", i), badHigh, 0);
            checkOutput($sformatf("f%0d_bad_low", i), badLow, 0);
            checkOutput($sformatf("f%0d_buttons", i), btn, {48'b0, vecs[i].expButtons});
            checkOutput($sformatf("f%0d_pressed", i), prs, {48'b0, vecs[i].expPressed});
            checkOutput($sformatf("f%0d_released", i), rel, {48'b0, vecs[i].expReleased});
            if (i > 0) checkOutput($sformatf("f%0d_period", i), riseCyc - prevRise, 15000);
            prevRise = riseCyc;
            @(negedge clock);
            checkOutput($sformatf("f%0d_fv_pulse", i), fvA, 0);
            checkOutput($sformatf("f%0d_busy_after", i), busyA, 0);
        end

        // Drop poll_en during CLK_HI: frame completes, nothing further starts.
        resetN = 1'b0;
        repeat (2) @(negedge clock);
        checkOutput("rst2_buttons", buttonsA, 0);
        resetN = 1'b1;
        applyStimulus(8'hFE, 8'hFF);
        found = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clock);
            if (pclkA) begin found = 1'b1; break; end
        end
        checkOutput("drop_saw_clkhi", found, 1);
        pollEnA = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clock);
            if (fvA) begin found = 1'b1; break; end
        end
        checkOutput("drop_frame_done", found, 1);
        checkOutput("drop_buttons", buttonsA, 16'h0001);
        checkOutput("drop_pressed", pressedA, 16'h0001);
        seen = 0;
        for (int k = 0; k < 15100; k++) begin
            @(negedge clock);
            if (latchA) seen++;
        end
        checkOutput("drop_no_latch", seen, 0);
        checkOutput("drop_busy", busyA, 0);

        // Re-enable with the counter expired: latch on the very next cycle.
        applyStimulus(8'hFE, 8'h7F);
        pollEnA = 1'b1;
        @(negedge clock);
        checkOutput("reenable_latch", latchA, 1);

        // Reset during the 4th pad_clk pulse.
        rises = 0; prevP = 1'b0;
        for (int k = 0; k < 100 && rises < 4; k++) begin
            @(negedge clock);
            if (pclkA && !prevP) rises++;
            prevP = pclkA;
        end
        checkOutput("midrst_reached_pulse4", rises, 4);
        checkOutput("midrst_buttons_before", buttonsA, 16'h0001);
        resetN = 1'b0;
        #1;
        checkOutput("midrst_latch",   latchA,   0);
        checkOutput("midrst_padclk",  pclkA,    0);
        checkOutput("midrst_buttons", buttonsA, 0);
        checkOutput("midrst_busy",    busyA,    0);
        repeat (2) @(negedge clock);
        resetN = 1'b1;
        walkFrame(1'b0, riseCyc, latchLen, pulses, badHigh, badLow, fvIdx, btn, prs, rel);
        checkOutput("postrst_fv_latency", fvIdx, 57);
        checkOutput("postrst_buttons", btn, 64'h8001);
        checkOutput("postrst_pressed", prs, 64'h8001);
        checkOutput("postrst_released", rel, 64'h0);

        // Wide configuration: 4 pads x 16 bits, short interval shorter than the frame.
        patB[0] = 16'hFFFE;
        patB[1] = 16'h7FFF;
        patB[2] = 16'hA5A5;
        patB[3] = 16'hFFFF;
        pollEnB = 1'b1;
        walkFrame(1'b1, riseCyc, latchLen, pulses, badHigh, badLow, fvIdx, btn, prs, rel);
        checkOutput("wide_fv_latency", fvIdx, 136);
        checkOutput("wide_latch_len", latchLen, 11);
        checkOutput("wide_pulses", pulses, 15);
        checkOutput("wide_bad_high", badHigh, 0);
        checkOutput("wide_bad_low", badLow, 0);
        checkOutput("wide_buttons", btn, 64'h0000_5A5A_8000_0001);
        checkOutput("wide_pressed", prs, 64'h0000_5A5A_8000_0001);
        checkOutput("wide_released", rel, 64'h0);
        prevRise = riseCyc;
        walkFrame(1'b1, riseCyc, latchLen, pulses, badHigh, badLow, fvIdx, btn, prs, rel);
        checkOutput("wide_back_to_back", riseCyc - prevRise, 137);
        checkOutput("wide_f2_buttons", btn, 64'h0000_5A5A_8000_0001);
        checkOutput("wide_f2_pressed", prs, 64'h0);
        checkOutput("wide_f2_released", rel, 64'h0);
        pollEnB = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/nes_multipad_reader.md
Name: nes_multipad_reader

Overview:
Parametrised successor to the single-pad NES serial reader. Generates the latch and serial-clock waveforms shared by NUM_PADS controllers and deserialises every pad's data line in parallel. Polls automatically at a programmable interval and presents active-high button vectors with per-frame pressed/released edge flags. Sits between the controller connector pins and the game logic.

Parameters:
NUM_PADS, 2, number of controllers sharing latch and clock.
BITS, 8, bits shifted per pad per frame (8 for NES, 16 for SNES-style pads).
HALF_PERIOD, 3, clk cycles per half period of pad_clk; legal range is 3 or more.
LATCH_CYCLES, 11, clk cycles latch_out is held high (about 12 us at 900 kHz).
POLL_INTERVAL, 15000, clk cycles from one frame start to the next (about 60 Hz).

Ports:
clk_900KHz  input  1  system clock; all logic on its rising edge.
reset  input  1  asynchronous, active-low reset.
data_in  input  NUM_PADS  serial data from each pad; active-low (0 = pressed).
poll_en  input  1  1 = automatic polling enabled.
latch_out  output  1  latch strobe to all pads.
pad_clk_out  output  1  serial shift clock to all pads; idles low.
buttons  output  NUM_PADS*BITS  registered state, active-high; pad p, bit i at index p*BITS+i; bit 0 is the first bit shifted (A).
pressed  output  NUM_PADS*BITS  1 for one frame where a button went 0 to 1.
released  output  NUM_PADS*BITS  1 for one frame where a button went 1 to 0.
frame_valid  output  1  one-cycle pulse when buttons, pressed and released update.
busy  output  1  high from LATCH entry through UPDATE.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE, interval counter 0; latch_out, pad_clk_out, buttons, pressed, released, frame_valid and busy all 0. Shift registers and synchronisers clear to all-1 (released level).
- data_in passes through a 2-FF synchroniser per pad. Sample points sit at least 3 cycles after the shifting edge, which covers the synchroniser delay.
- FSM states: IDLE, LATCH, GAP, CLK_HI, CLK_LO, UPDATE.
- IDLE: leaves to LATCH when poll_en=1 and the interval counter is 0. The counter reloads to POLL_INTERVAL-1 on LATCH entry and decrements to 0, saturating there.
- LATCH: latch_out=1 for LATCH_CYCLES cycles, then GAP.
- GAP: latch_out=0, pad_clk_out=0 for HALF_PERIOD cycles. On the last cycle, shift in bit 0 from each synchronised data line.
- CLK_HI: pad_clk_out=1 for HALF_PERIOD cycles.
- CLK_LO: pad_clk_out=0 for HALF_PERIOD cycles. On the last cycle, shift in the next bit. A bit counter tracks progress: go to CLK_HI if fewer than BITS bits have been taken, otherwise go to UPDATE. There are exactly BITS-1 pad_clk pulses per frame.
- UPDATE: one cycle.
  - new = ~shift (converts to active-high).
  - pressed <= new & ~buttons; released <= ~new & buttons; buttons <= new.
  - frame_valid=1.
  - Next state is IDLE.
- Frame length is LATCH_CYCLES + HALF_PERIOD + (BITS-1)*2*HALF_PERIOD + 1 cycles. Defaults give 57.
- pressed and released hold until the next UPDATE, which overwrites them.
- If POLL_INTERVAL is at most the frame length, the counter is already 0 at IDLE and the next frame starts on the following cycle.
- poll_en=0 mid-frame: the frame completes normally including UPDATE; no new frame starts. poll_en re-asserted with the counter at 0: LATCH on the next cycle.
- The first frame after reset compares against buttons=0, so buttons held at power-up appear in pressed.
- A disconnected pad reads all 1 (pulled up), giving buttons=0.
- Reset mid-frame: outputs drop to reset values immediately and no partial frame is published.
- busy=1 in every state except IDLE.

Test Plan:
- Reset then release with poll_en=0 -> all outputs 0 indefinitely; latch_out never rises.
- poll_en=1, pad0 model presenting active-low 8'b11111110 (A held), pad1 all 1 -> first frame_valid 57 cycles after LATCH entry; latch_out high 11 cycles; 7 pad_clk pulses of 3 high/3 low; buttons[7:0]=8'h01, buttons[15:8]=0, pressed[0]=1.
- Next frame with A released and Right (bit 7) held on pad1 -> released[0]=1, pressed[15]=1, buttons=16'h8000; frames start exactly 15000 cycles apart.
- Unchanged input over two frames -> pressed=0 and released=0 after the second frame_valid.
- poll_en dropped during CLK_HI of frame N -> frame N completes with frame_valid; no LATCH afterwards; busy=0.
- reset asserted during the 4th pad_clk pulse -> latch_out, pad_clk_out, buttons and busy go 0 immediately; after release, the first frame reports held buttons in pressed.
- NUM_PADS=4, BITS=16, HALF_PERIOD=4 -> 15 pulses per frame; frame length 11+4+120+1=136; each pad decoded independently.
